// File: rtl/twos_comp_pkg.sv
// Shared types and constants for the two's-complementer datapath
// (serial negation engine and the downstream 2:1 output mux).
package twos_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Counter must reach WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_comp_bit.sv
// One-bit COPY/INVERT cell: passes bits through until the first 1 has
// been consumed, then inverts every later bit.
module serial_comp_bit (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  input  logic serial_bit,
  output logic comp_bit
);

  logic seen_one;

  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      seen_one <= 1'b0;
    end else if (enable) begin
      seen_one <= seen_one | serial_bit;
    end
  end

  assign comp_bit = seen_one ? ~serial_bit : serial_bit;

endmodule

// File: rtl/serial_twos_complementer.sv
// Bit-serial two's-complement negator: captures a WIDTH-bit operand, negates
// it LSB-first over WIDTH cycles and holds the result until handshaken.
module serial_twos_complementer
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Sign,
  output logic             Ovf,
  output logic             Busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] out_word;
  logic             sign_q;
  logic             ovf_q;
  logic             capture;
  logic             shifting;
  logic             comp_bit;
  logic [WIDTH-1:0] res_next;

  assign capture  = (state == IDLE) && In_Valid;
  assign shifting = (state == SHIFT);
  assign res_next = {comp_bit, res[WIDTH-1:1]};

  serial_comp_bit u_bit (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (capture),
    .enable     (shifting),
    .serial_bit (src[0]),
    .comp_bit   (comp_bit)
  );

  // res accumulates partial bits; out_word only updates on the final step so
  // Out_Data never exposes an in-flight value.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      src      <= '0;
      res      <= '0;
      out_word <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (In_Valid) begin
            src    <= In_Data;
            sign_q <= In_Data[WIDTH-1];
            ovf_q  <= (In_Data == MOST_NEG);
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          src <= src >> 1;
          res <= res_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            out_word <= res_next;
            state    <= DONE;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign In_Ready  = (state == IDLE);
  assign Out_Valid = (state == DONE);
  assign Busy      = shifting;
  assign Out_Data  = out_word;
  assign Sign      = sign_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Self-checking bench for serial_twos_complementer at WIDTH = 4.
module tb_serial_twos_complementer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         sign;
  logic         ovf;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last_res;

  typedef struct {
    logic [W-1:0] op;
    int           hold;
    logic [W-1:0] exp_data;
    logic         exp_sign;
    logic         exp_ovf;
    logic [W-1:0] exp_abs;
  } vec_t;

  vec_t vecs[7];

  serial_twos_complementer #(.WIDTH(W)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_Data   (in_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_Data  (out_data),
    .Sign      (sign),
    .Ovf       (ovf),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: negation as plain modular arithmetic.
  function automatic logic [W-1:0] model_neg(input logic [W-1:0] op);
    return W'((2 ** W - int'(op)) % (2 ** W));
  endfunction

  function automatic logic [W-1:0] model_abs(input logic [W-1:0] op);
    return (int'(op) >= 2 ** (W - 1)) ? model_neg(op) : op;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_sign"}, sign, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Full transaction; all driving and sampling on the falling edge.
  task automatic run_op(input logic [W-1:0] op, input int hold,
                        input logic [W-1:0] exp_data, input logic exp_sign,
                        input logic exp_ovf, input logic [W-1:0] exp_abs,
                        input bit inject);
    int n = 0;
    int bcnt = 0;
    logic [W-1:0] mux_out;
    chk("in_ready_before_load", in_ready, 1);
    in_valid = 1'b1;
    in_data  = op;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      if (busy) bcnt++;
      if (out_data !== last_res) chk("out_data_stable_in_shift", out_data, last_res);
      if (inject && n == 1) begin
        in_valid = 1'b1;
        in_data  = 4'b0110;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, W);
    chk("busy_cycles", bcnt, W);
    chk("out_data", out_data, exp_data);
    chk("sign", sign, exp_sign);
    chk("ovf", ovf, exp_ovf);
    mux_out = sign ? out_data : op;
    chk("mux_abs", mux_out, exp_abs);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, exp_data);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("out_data_held_after_hs", out_data, exp_data);
    last_res = exp_data;
  endtask

  initial begin
    logic [W-1:0] r;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    last_res  = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{4'b0101, 0, 4'b1011, 1'b0, 1'b0, 4'b0101};
    vecs[1] = '{4'b1111, 0, 4'b0001, 1'b1, 1'b0, 4'b0001};
    vecs[2] = '{4'b0000, 0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[3] = '{4'b1000, 0, 4'b1000, 1'b1, 1'b1, 4'b1000};
    vecs[4] = '{4'b0011, 5, 4'b1101, 1'b0, 1'b0, 4'b0011};
    vecs[5] = '{4'b0111, 1, 4'b1001, 1'b0, 1'b0, 4'b0111};
    vecs[6] = '{4'b1110, 2, 4'b0010, 1'b1, 1'b0, 4'b0010};
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_sign,
             vecs[i].exp_ovf, vecs[i].exp_abs, 1'b0);

    // In_Valid pulsed with 0110 during SHIFT of 0001 must be ignored.
    run_op(4'b0001, 0, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("no_second_valid", out_valid, 0);
      chk("no_second_busy", busy, 0);
    end

    // Reset at SHIFT step 2 of 0111 aborts the operation.
    in_valid = 1'b1;
    in_data  = 4'b0111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("mid_shift_reset");
    last_res = '0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("no_valid_after_abort", out_valid, 0);
    end
    run_op(4'b0010, 0, 4'b1110, 1'b0, 1'b0, 4'b0010, 1'b0);

    // Reset while parked in DONE with Out_Ready low.
    in_valid = 1'b1;
    in_data  = 4'b0101;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("done_parked_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("done_reset");
    last_res = '0;

    for (int i = 0; i < 24; i++) begin
      r = W'($urandom_range(0, 2 ** W - 1));
      run_op(r, int'($urandom_range(0, 2)), model_neg(r), r[W-1],
             (r == 4'b1000), model_abs(r), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
